// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory with boot loader.
package instr_mem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WFLUSH,
        ST_RUN
    } load_state_e;

endpackage

// File: rtl/instr_mem_bram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module instr_mem_bram
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates on a read, so the last result is held between fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with byte-stream boot loader and gated pipelined fetch port.
// Optional range checking of fetches is enabled by defining INSTR_MEM_BOUNDS_CHECK_EN.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              io_byte_valid,
    input  logic [7:0]        io_byte,
    output logic              io_byte_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    output logic              fetch_fault,
`endif
    output logic [DATA_W-1:0] fetch_data
);

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    load_state_e       state_q, state_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              fvalid_q;

    logic [ADDR_W:0]   issue_idx;
    logic [DATA_W-1:0] asm_word;
    logic              byte_accept;
    logic              fetch_accept;
    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_fetch_bits;

    assign io_byte_ready = (state_q == ST_LOAD);
    assign load_busy     = (state_q == ST_LOAD) || (state_q == ST_WFLUSH);
    assign load_done     = done_q;
    assign words_loaded  = wptr_q;
    assign fetch_ready   = (state_q == ST_RUN);
    assign fetch_valid   = fvalid_q;
    assign fetch_accept  = fetch_req && fetch_ready;
    assign fetch_idx     = fetch_addr[ADDR_W+1:2];

    // Next-state logic: byte packing, word issue and load sequencing.
    // A word still waiting to be written counts towards the next write address,
    // so narrow words arriving every cycle never reuse a slot.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        byte_accept = (state_q == ST_LOAD) && io_byte_valid;
        issue_idx   = wptr_q + {{ADDR_W{1'b0}}, wr_pend_q};
        asm_word    = shift_q;
        asm_word[8*byte_cnt_q +: 8] = io_byte;

        if (wr_pend_q) begin
            wptr_d = wptr_q + ONE;
        end

        case (state_q)
            ST_LOAD: begin
                if (byte_accept) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        wr_pend_d  = 1'b1;
                        wr_addr_d  = issue_idx[ADDR_W-1:0];
                        wr_data_d  = asm_word;
                        if (issue_idx + ONE == len_q) begin
                            state_d = ST_WFLUSH;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = asm_word;
                    end
                end
            end
            ST_WFLUSH: begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end
            default: ;
        endcase

        // A new load overrides everything, including an in-progress load.
        if (load_start) begin
            len_d      = (load_len > DEPTH) ? DEPTH : load_len;
            wptr_d     = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            wr_pend_d  = 1'b0;
            if (len_d == '0) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end else begin
                state_d = ST_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    instr_mem_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_pend_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (fetch_accept),
        .raddr_i (fetch_idx),
        .rdata_o (ram_rdata)
    );

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    logic fzero_q;
    logic fetch_oob;

    assign fetch_oob = ({1'b0, fetch_idx} >= wptr_q) || ((fetch_addr >> (ADDR_W + 2)) != 32'd0);

    // The zero flag is held with the read data so a faulted result stays 0 until the next fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvalid_q <= 1'b0;
            fzero_q  <= 1'b0;
        end else begin
            fvalid_q <= fetch_accept;
            if (fetch_accept) begin
                fzero_q <= fetch_oob;
            end
        end
    end

    assign fetch_fault       = fvalid_q && fzero_q;
    assign fetch_data        = fzero_q ? '0 : ram_rdata;
    assign unused_fetch_bits = ^fetch_addr[1:0];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvalid_q <= 1'b0;
        end else begin
            fvalid_q <= fetch_accept;
        end
    end

    assign fetch_data        = ram_rdata;
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader with a fetch scoreboard and a small memory model.
// Define INSTR_MEM_BOUNDS_CHECK_EN to exercise the range-checked fetch path.
module tb_instr_mem_loader;

    localparam int AW = 4;
    localparam int NW = 1 << AW;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          io_byte_valid = 1'b0;
    logic [7:0]    io_byte = '0;
    logic          io_byte_ready;
    logic          load_busy;
    logic          load_done;
    logic [AW:0]   words_loaded;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    logic          fetch_fault;
`endif

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            done_count = 0;
    exp_t          sbq[$];
    logic [31:0]   model_mem [NW];
    logic [AW:0]   model_words = '0;
    logic          model_run = 1'b0;

    instr_mem_loader #(
        .ADDR_W (AW),
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_len      (load_len),
        .io_byte_valid (io_byte_valid),
        .io_byte       (io_byte),
        .io_byte_ready (io_byte_ready),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .words_loaded  (words_loaded),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
        .fetch_fault   (fetch_fault),
`endif
        .fetch_data    (fetch_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: every fetch result is matched in order against what the model predicted.
    always @(negedge clk) begin
        exp_t e;
        if (load_done === 1'b1) done_count++;
        if (fetch_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL fetch_unexpected: fetch_valid=1 data=%h, required no result", fetch_data);
            end else begin
                e = sbq.pop_front();
                if (fetch_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL fetch_data: got %h required %h", fetch_data, e.data);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL fetch_latency: result at cycle %0d required cycle %0d", cyc, e.due);
                end
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
                checks++;
                if (fetch_fault !== e.fault) begin
                    errors++;
                    $display("[TB] FAIL fetch_fault: got %b required %b", fetch_fault, e.fault);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t expect_fetch(input logic [31:0] addr);
        exp_t        e;
        logic [AW-1:0] idx;
        idx     = addr[AW+1:2];
        e.data  = model_mem[idx];
        e.fault = 1'b0;
        e.due   = 0;
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
        if (({1'b0, idx} >= model_words) || ((addr >> (AW + 2)) != 32'd0)) begin
            e.data  = '0;
            e.fault = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic start_load(input logic [AW:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, output bit ok);
        int t = 0;
        io_byte_valid = 1'b1;
        io_byte       = b;
        while (io_byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = (io_byte_ready === 1'b1);
        @(negedge clk);
        io_byte_valid = 1'b0;
    endtask

    task automatic issue_fetch(input logic [31:0] addr);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        if (model_run) begin
            e     = expect_fetch(addr);
            e.due = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (io_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_io_byte_ready: got %b required 0", io_byte_ready); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_busy: got %b required 0", load_busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b required 0", load_done); end
        checks++; if (words_loaded !== '0) begin errors++; $display("[TB] FAIL reset_words_loaded: got %0d required 0", words_loaded); end
        checks++; if (fetch_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_fetch_data: got %h required 0", fetch_data); end
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_fault: got %b required 0", fetch_fault); end
`endif
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_fetch_ready: got %b required 0", fetch_ready); end
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_fetch_valid: got %b required 0", fetch_valid); end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_basic_load();
        logic [7:0] img [8];
        bit ok;
        int t = 0;
        int d0 = done_count;
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        start_load(2);
        checks++; if (load_busy !== 1'b1) begin errors++; $display("[TB] FAIL load_busy: got %b required 1", load_busy); end
        checks++; if (io_byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready: got %b required 1", io_byte_ready); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_fetch_ready: got %b required 0", fetch_ready); end
        for (int i = 0; i < 8; i++) begin
            push_byte(img[i], ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_byte_timeout: byte %0d ready=%b required 1", i, io_byte_ready); end
        end
        checks++; if (io_byte_ready !== 1'b0 || load_busy !== 1'b1) begin errors++; $display("[TB] FAIL wflush_state: ready=%b busy=%b required 0/1", io_byte_ready, load_busy); end
        while (load_done !== 1'b1 && t < 8) begin @(negedge clk); t++; end
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_timeout: load_done=%b required 1", load_done); end
        checks++; if (words_loaded !== 5'd2) begin errors++; $display("[TB] FAIL basic_words_loaded: got %0d required 2", words_loaded); end
        checks++; if (fetch_ready !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_run_state: ready=%b busy=%b required 1/0", fetch_ready, load_busy); end
        model_mem[0] = 32'h0010_0513;
        model_mem[1] = 32'h0020_0593;
        model_words  = 2;
        model_run    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d required 1", done_count - d0); end
        issue_fetch(32'h0);
        fetch_req = 1'b0;
        @(negedge clk);
        issue_fetch(32'h4);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL basic_drain: %0d results outstanding, required 0", sbq.size()); end
    endtask

    task automatic test_back_to_back();
        issue_fetch(32'h4);
        issue_fetch(32'h0);
        issue_fetch(32'h4);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain: %0d results outstanding, required 0", sbq.size()); end
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== model_mem[1]) begin errors++; $display("[TB] FAIL b2b_hold: valid=%b data=%h required 0/%h", fetch_valid, fetch_data, model_mem[1]); end
    endtask

    task automatic test_zero_len();
        int d0 = done_count;
        io_byte_valid = 1'b1;
        io_byte       = 8'hFF;
        start_load(0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b required 1", load_done); end
        checks++; if (fetch_ready !== 1'b1 || io_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_run: fetch_ready=%b io_ready=%b required 1/0", fetch_ready, io_byte_ready); end
        checks++; if (words_loaded !== '0) begin errors++; $display("[TB] FAIL zero_words: got %0d required 0", words_loaded); end
        model_words = 0;
        repeat (3) @(negedge clk);
        io_byte_valid = 1'b0;
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL zero_done_pulses: got %0d required 1", done_count - d0); end
        issue_fetch(32'h0);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL zero_drain: %0d results outstanding, required 0", sbq.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        int fails = 0;
        int t = 0;
        int d0 = done_count;
        logic [7:0] b;
        start_load(5'(NW + 1));
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((w << 4) + k + 1);
                push_byte(b, ok);
                if (!ok) fails++;
                model_mem[w][8*k +: 8] = b;
            end
        end
        checks++; if (fails != 0) begin errors++; $display("[TB] FAIL ovf_byte_timeout: %0d bytes not accepted, required 0", fails); end
        io_byte_valid = 1'b1;
        io_byte       = 8'hEE;
        checks++; if (io_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_extra_ready: got %b required 0", io_byte_ready); end
        while (load_done !== 1'b1 && t < 8) begin @(negedge clk); t++; end
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done_timeout: load_done=%b required 1", load_done); end
        repeat (3) @(negedge clk);
        checks++; if (words_loaded !== 5'(NW)) begin errors++; $display("[TB] FAIL ovf_words: got %0d required %0d", words_loaded, NW); end
        checks++; if (io_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready_after: got %b required 0", io_byte_ready); end
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL ovf_done_pulses: got %0d required 1", done_count - d0); end
        io_byte_valid = 1'b0;
        model_words   = 5'(NW);
        issue_fetch(32'h3C);
        issue_fetch(32'h0);
        issue_fetch(32'h44);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL ovf_drain: %0d results outstanding, required 0", sbq.size()); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] img_a [5];
        logic [7:0] img_b [8];
        bit ok;
        int t = 0;
        int d0;
        img_a = '{8'hB7, 8'h02, 8'h00, 8'h10, 8'h37};
        img_b = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        start_load(2);
        for (int i = 0; i < 5; i++) begin
            push_byte(img_a[i], ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_byte_timeout: byte %0d not accepted", i); end
        end
        model_mem[0] = {img_a[3], img_a[2], img_a[1], img_a[0]};
        rst = 1'b1;
        #1;
        checks++; if (io_byte_ready !== 1'b0 || load_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_state: ready=%b busy=%b required 0/0", io_byte_ready, load_busy); end
        checks++; if (words_loaded !== '0) begin errors++; $display("[TB] FAIL mid_rst_words: got %0d required 0", words_loaded); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_fetch_ready: got %b required 0", fetch_ready); end
        @(negedge clk);
        rst         = 1'b0;
        model_run   = 1'b0;
        model_words = 0;
        @(negedge clk);
        checks++; if (io_byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle_ready: got %b required 0", io_byte_ready); end
        d0 = done_count;
        start_load(2);
        for (int i = 0; i < 8; i++) begin
            push_byte(img_b[i], ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL reload_byte_timeout: byte %0d not accepted", i); end
        end
        while (load_done !== 1'b1 && t < 8) begin @(negedge clk); t++; end
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL reload_done_timeout: load_done=%b required 1", load_done); end
        checks++; if (words_loaded !== 5'd2) begin errors++; $display("[TB] FAIL reload_words: got %0d required 2", words_loaded); end
        model_mem[0] = 32'h0000_006F;
        model_mem[1] = 32'h0000_0013;
        model_words  = 2;
        model_run    = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL reload_done_pulses: got %0d required 1", done_count - d0); end
        issue_fetch(32'h0);
        issue_fetch(32'h8);
        issue_fetch(32'h4);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL reload_drain: %0d results outstanding, required 0", sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_zero_len();
        test_overflow();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
